// File: rtl/watch_pkg.sv
// Shared definitions for the digital watch time stages (seconds, minutes, hours).
package watch_pkg;

  localparam int unsigned TIME_W = 6;
  localparam logic [TIME_W-1:0] SEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET    = 2'd1,
    RESYNC = 2'd2
  } watch_state_e;

  // Modulo-60 increment shared by the seconds and minutes fields.
  function automatic logic [TIME_W-1:0] time_inc(input logic [TIME_W-1:0] value);
    return (value == SEC_MAX) ? '0 : value + TIME_W'(1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock divider producing a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + CNT_W'(1);
    end
  end

  assign tick = enable && !clear && (div_cnt == LAST);

endmodule

// File: rtl/second_counter.sv
// Seconds stage of the watch: 1 Hz run-mode counting plus one-step-per-press manual setting.
module second_counter
  import watch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              change_second,
  input  logic              valid_response,
  output logic [TIME_W-1:0] second,
  output logic              sec_tick,
  output logic              min_carry
);

  watch_state_e state, state_nxt;

  logic press;
  logic press_q;
  logic press_rise;
  logic run_enable;
  logic run_tick;

  assign press      = mode & change_second & valid_response;
  assign press_rise = press & ~press_q;

  // A rising mode pre-empts a pending run-mode tick, so the timebase is gated by ~mode too.
  assign run_enable = (state == RUN) && !mode;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (run_enable),
    .clear  (!run_enable),
    .tick   (run_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: next-state is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (mode)  state_nxt = SET;
      SET:     if (!mode) state_nxt = RESYNC;
      RESYNC:  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // NOTE: synchronous reset here must dominate both the press edge and the prescaler tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      second    <= '0;
      sec_tick  <= 1'b0;
      min_carry <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      press_q   <= press;
      sec_tick  <= 1'b0;
      min_carry <= 1'b0;
      if (run_tick) begin
        second    <= time_inc(second);
        sec_tick  <= 1'b1;
        min_carry <= (second == SEC_MAX);
      end else if (press_rise) begin
        // Manual steps never raise strobes; press already implies mode, so it is honoured in any state.
        second <= time_inc(second);
      end
    end
  end

endmodule

// File: tb/tb_second_counter.sv
// Directed self-checking bench for second_counter with TICK_DIV=4.
module tb_second_counter;
  import watch_pkg::*;

  localparam int unsigned TICK_DIV = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              mode;
  logic              change_second;
  logic              valid_response;
  logic [TIME_W-1:0] second;
  logic              sec_tick;
  logic              min_carry;

  int checks   = 0;
  int failures = 0;
  int exp_sec;

  second_counter #(
    .TICK_DIV (TICK_DIV)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .mode           (mode),
    .change_second  (change_second),
    .valid_response (valid_response),
    .second         (second),
    .sec_tick       (sec_tick),
    .min_carry      (min_carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge for sampling and driving.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input int exp_second, input int exp_tick,
                               input int exp_carry);
    check({tag, ".second"},    int'(second),    exp_second);
    check({tag, ".sec_tick"},  int'(sec_tick),  exp_tick);
    check({tag, ".min_carry"}, int'(min_carry), exp_carry);
  endtask

  task automatic press_once();
    change_second  = 1'b1;
    valid_response = 1'b1;
    step(1);
    change_second  = 1'b0;
    valid_response = 1'b0;
    step(1);
  endtask

  initial begin
    rst            = 1'b1;
    mode           = 1'b0;
    change_second  = 1'b0;
    valid_response = 1'b0;
    step(3);

    check_outputs("reset", 0, 0, 0);
    check("reset.div_cnt", int'(u_dut.u_prescaler.div_cnt), 0);
    check("reset.press_q", int'(u_dut.press_q), 0);
    check("reset.state",   int'(u_dut.state),   int'(RUN));

    // Run from reset: first increment on the 4th edge, second on the 8th.
    rst = 1'b0;
    step(1);
    check("run.div_after_1", int'(u_dut.u_prescaler.div_cnt), 1);
    step(2);
    check_outputs("run.edge3", 0, 0, 0);
    step(1);
    check_outputs("run.edge4", 1, 1, 0);
    step(1);
    check_outputs("run.edge5", 1, 0, 0);
    step(3);
    check_outputs("run.edge8", 2, 1, 0);

    // Continue to the 59 -> 0 wrap at edge 240.
    step(228);
    check_outputs("run.edge236", 59, 1, 0);
    step(3);
    check_outputs("run.edge239", 59, 0, 0);
    step(1);
    check_outputs("run.wrap240", 0, 1, 1);
    step(1);
    check_outputs("run.edge241", 0, 0, 0);

    // Enter set mode: prescaler cleared, three separate presses.
    mode = 1'b1;
    step(1);
    check("set.state", int'(u_dut.state), int'(SET));
    check("set.div_cnt", int'(u_dut.u_prescaler.div_cnt), 0);
    for (int i = 1; i <= 3; i++) begin
      change_second  = 1'b1;
      valid_response = 1'b1;
      step(1);
      check_outputs($sformatf("set.press%0d", i), i, 0, 0);
      change_second  = 1'b0;
      valid_response = 1'b0;
      step(2);
    end
    check("set.div_held", int'(u_dut.u_prescaler.div_cnt), 0);

    // Holding the button for 20 cycles gives a single step.
    change_second  = 1'b1;
    valid_response = 1'b1;
    step(20);
    check_outputs("set.held20", 4, 0, 0);
    change_second  = 1'b0;
    valid_response = 1'b0;
    step(2);

    // Step up to 59, then one press wraps to 0 without a carry.
    exp_sec = 4;
    repeat (55) begin
      press_once();
      exp_sec++;
    end
    check("set.reach59", int'(second), exp_sec);
    change_second  = 1'b1;
    valid_response = 1'b1;
    step(1);
    check_outputs("set.wrap", 0, 0, 0);

    // Drop mode while the button is still held: no extra step.
    mode = 1'b0;
    step(1);
    check_outputs("leave.held", 0, 0, 0);
    check("leave.state_resync", int'(u_dut.state), int'(RESYNC));
    change_second  = 1'b0;
    valid_response = 1'b0;
    step(1);
    check("leave.state_run", int'(u_dut.state), int'(RUN));
    check("leave.div_cnt", int'(u_dut.u_prescaler.div_cnt), 0);
    step(3);
    check_outputs("leave.edge3", 0, 0, 0);
    step(1);
    check_outputs("leave.edge4", 1, 1, 0);

    // Raise mode in the cycle where div_cnt is 3: no increment, no strobes.
    step(3);
    check("mode_race.div3", int'(u_dut.u_prescaler.div_cnt), 3);
    mode = 1'b1;
    step(1);
    check_outputs("mode_race", 1, 0, 0);
    check("mode_race.div_cnt", int'(u_dut.u_prescaler.div_cnt), 0);
    check("mode_race.state", int'(u_dut.state), int'(SET));
    step(1);
    check_outputs("mode_race.next", 1, 0, 0);

    // Press edge arriving in the same cycle mode rises is honoured.
    mode = 1'b0;
    step(2);
    check("press_race.state_run", int'(u_dut.state), int'(RUN));
    mode           = 1'b1;
    change_second  = 1'b1;
    valid_response = 1'b1;
    step(1);
    check_outputs("press_race", 2, 0, 0);
    check("press_race.state", int'(u_dut.state), int'(SET));
    change_second  = 1'b0;
    valid_response = 1'b0;
    step(1);

    // Set 37, return to run mode part-way into a prescale, then reset with a press active.
    repeat (35) press_once();
    check("pre_rst.second", int'(second), 37);
    mode = 1'b0;
    step(2);
    step(2);
    check("pre_rst.div_cnt", int'(u_dut.u_prescaler.div_cnt), 2);
    rst            = 1'b1;
    mode           = 1'b1;
    change_second  = 1'b1;
    valid_response = 1'b1;
    step(1);
    check_outputs("mid_rst", 0, 0, 0);
    check("mid_rst.div_cnt", int'(u_dut.u_prescaler.div_cnt), 0);
    check("mid_rst.state",   int'(u_dut.state),   int'(RUN));
    check("mid_rst.press_q", int'(u_dut.press_q), 0);
    rst            = 1'b0;
    mode           = 1'b0;
    change_second  = 1'b0;
    valid_response = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
